// File: rtl/excl_mon_pkg.sv
// excl_mon_pkg: shared definitions for the exclusion-window monitor.
//   excl_state_e   : per-channel checker state (IDLE, GRACE, ARMED, TRIPPED)
//   GRACE_W        : width of the per-channel grace counter
//   lowest_set_idx : index of the lowest set bit, used for first-offender priority
package excl_mon_pkg;

    localparam int unsigned GRACE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRACE,
        ST_ARMED,
        ST_TRIPPED
    } excl_state_e;

    function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
        logic [4:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (vec[i] && !found) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/excl_mon_chan.sv
// excl_mon_chan: one guard/event channel of the exclusion-window monitor.
// FSM with grace counter; reports at most one violation per guard episode.
// Optional saturating violation counter built when EXCL_MON_COUNT_EN is defined.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   mon_en         : low forces IDLE and suppresses violations
//   clr            : synchronous clear of the violation counter
//   guard, event_i : channel guard and event
//   viol_o         : combinational violation detected at this edge
//   viol_pulse_o   : registered one-cycle violation strobe
//   cnt_o          : saturating violation count (0 when counters not built)
module excl_mon_chan
    import excl_mon_pkg::*;
#(
    parameter int unsigned GRACE_CYCLES = 0,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mon_en,
    input  logic             clr,
    input  logic             guard,
    input  logic             event_i,
    output logic             viol_o,
    output logic             viol_pulse_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam bit HAS_GRACE = (GRACE_CYCLES > 0);
    localparam logic [GRACE_W-1:0] GRACE_LOAD =
        HAS_GRACE ? GRACE_W'(GRACE_CYCLES - 1) : '0;

    excl_state_e        state_q, state_d;
    logic [GRACE_W-1:0] grace_q, grace_d;
    logic               viol_d;
    logic               pulse_q;

    // Guard-high edges ignored are the rising edge plus GRACE_CYCLES-1 more,
    // so GRACE hands over to ARMED on the edge where the counter would reach 0.
    always_comb begin
        state_d = state_q;
        grace_d = grace_q;
        viol_d  = 1'b0;
        if (!mon_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (guard) begin
                        if (!HAS_GRACE) begin
                            if (event_i) begin
                                viol_d  = 1'b1;
                                state_d = ST_TRIPPED;
                            end else begin
                                state_d = ST_ARMED;
                            end
                        end else if (GRACE_LOAD == '0) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_GRACE;
                            grace_d = GRACE_LOAD;
                        end
                    end
                end
                ST_GRACE: begin
                    if (!guard) begin
                        state_d = ST_IDLE;
                    end else begin
                        grace_d = grace_q - GRACE_W'(1);
                        if (grace_q == GRACE_W'(1)) begin
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (!guard) begin
                        state_d = ST_IDLE;
                    end else if (event_i) begin
                        viol_d  = 1'b1;
                        state_d = ST_TRIPPED;
                    end
                end
                ST_TRIPPED: begin
                    if (!guard) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grace_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grace_q <= grace_d;
            pulse_q <= viol_d;
        end
    end

    assign viol_o       = viol_d;
    assign viol_pulse_o = pulse_q;

`ifdef EXCL_MON_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear first, then count the violation of the same edge.
    always_comb begin
        cnt_d = clr ? '0 : cnt_q;
        if (viol_d && (cnt_d != '1)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign cnt_o      = '0;
`endif

endmodule

// File: rtl/excl_window_monitor.sv
// excl_window_monitor: multi-channel run-time checker for "while guard[i] is
// high, event_i[i] must stay low", with grace window, sticky flags, optional
// per-channel saturating counters (EXCL_MON_COUNT_EN) and first-offender capture.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   mon_en       : monitor enable
//   clr          : synchronous clear of sticky flags, counters, first capture
//   guard        : per-channel guard
//   event_i      : per-channel event
//   viol_pulse   : one-cycle violation strobe per channel
//   viol_sticky  : sticky violation flag per channel
//   viol_cnt     : packed counters, channel 0 in LSBs (0 without EXCL_MON_COUNT_EN)
//   first_vld    : first violation captured
//   first_ch     : index of first violating channel (lowest index on ties)
//   irq          : OR of viol_sticky
module excl_window_monitor
    import excl_mon_pkg::*;
#(
    parameter  int unsigned NUM_CH       = 4,
    parameter  int unsigned GRACE_CYCLES = 0,
    parameter  int unsigned CNT_W        = 8,
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mon_en,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       guard,
    input  logic [NUM_CH-1:0]       event_i,
    output logic [NUM_CH-1:0]       viol_pulse,
    output logic [NUM_CH-1:0]       viol_sticky,
    output logic [NUM_CH*CNT_W-1:0] viol_cnt,
    output logic                    first_vld,
    output logic [CH_W-1:0]         first_ch,
    output logic                    irq
);

    logic [NUM_CH-1:0] viol;
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic              first_vld_q, first_vld_d;
    logic [CH_W-1:0]   first_ch_q, first_ch_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        excl_mon_chan #(
            .GRACE_CYCLES (GRACE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk          (clk),
            .reset_n      (reset_n),
            .mon_en       (mon_en),
            .clr          (clr),
            .guard        (guard[i]),
            .event_i      (event_i[i]),
            .viol_o       (viol[i]),
            .viol_pulse_o (viol_pulse[i]),
            .cnt_o        (viol_cnt[i*CNT_W +: CNT_W])
        );
    end

    // Clear is applied before recording violations of the same edge.
    always_comb begin
        sticky_d    = (clr ? '0 : sticky_q) | viol;
        first_vld_d = clr ? 1'b0 : first_vld_q;
        first_ch_d  = clr ? '0 : first_ch_q;
        if (!first_vld_d && (|viol)) begin
            first_vld_d = 1'b1;
            first_ch_d  = CH_W'(lowest_set_idx(32'(viol)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_q    <= '0;
            first_vld_q <= 1'b0;
            first_ch_q  <= '0;
        end else begin
            sticky_q    <= sticky_d;
            first_vld_q <= first_vld_d;
            first_ch_q  <= first_ch_d;
        end
    end

    assign viol_sticky = sticky_q;
    assign first_vld   = first_vld_q;
    assign first_ch    = first_ch_q;
    assign irq         = |sticky_q;

endmodule
